// File: rtl/bcd_bin_seq.sv
// Sequential four-digit BCD to 16-bit binary converter (reverse double dabble),
// one bit per clock, with a start/busy/done handshake.
module bcd_bin_seq (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [3:0]  i_bcd3,
  input  logic [3:0]  i_bcd2,
  input  logic [3:0]  i_bcd1,
  input  logic [3:0]  i_bcd0,
  output logic [15:0] o_bi,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [1:0]  o_dbg_state
);

  // Handshake: a request is accepted on a rising edge where i_start=1 and
  // o_busy=0; o_done pulses for one cycle when o_bi/o_err become valid, and
  // any i_start seen while o_busy=1 is dropped, never queued.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_b;
  logic [15:0] r_r;
  logic [3:0]  r_cnt;
  logic [15:0] r_bi;
  logic        r_err;

  logic [15:0] w_bcd_in;
  logic        w_bad_digit;
  logic [31:0] w_shifted;
  logic [15:0] w_b_fixed;

  assign w_bcd_in    = {i_bcd3, i_bcd2, i_bcd1, i_bcd0};
  assign w_bad_digit = (i_bcd3 > 4'd9) || (i_bcd2 > 4'd9) ||
                       (i_bcd1 > 4'd9) || (i_bcd0 > 4'd9);
  assign w_shifted   = {r_b, r_r} >> 1;

  // A nibble that shifted in a "tens" bit now reads >= 8; subtracting 3
  // turns the weight-8 carry back into weight-5 decimal halving.
  always_comb begin
    w_b_fixed = w_shifted[31:16];
    for (int k = 0; k < 4; k++) begin
      if (w_shifted[16 + 4*k + 3]) begin
        w_b_fixed[4*k +: 4] = w_shifted[16 + 4*k +: 4] - 4'd3;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next_state = w_bad_digit ? S_DONE : S_SHIFT;
      S_SHIFT: if (r_cnt == 4'd15) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_b     <= '0;
      r_r     <= '0;
      r_cnt   <= '0;
      r_bi    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_b   <= w_bcd_in;
            r_r   <= '0;
            r_cnt <= '0;
            r_err <= w_bad_digit;
            if (w_bad_digit) r_bi <= '0;
          end
        end
        S_SHIFT: begin
          r_b   <= w_b_fixed;
          r_r   <= w_shifted[15:0];
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd15) r_bi <= w_shifted[15:0];
        end
        default: ;
      endcase
    end
  end

  assign o_bi        = r_bi;
  assign o_err       = r_err;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bcd_bin_seq.sv
// Bench for bcd_bin_seq: directed handshake scenarios plus randomized
// conversions checked against a decimal-arithmetic reference.
module tb_bcd_bin_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  bcd3, bcd2, bcd1, bcd0;
  logic [15:0] bi;
  logic        busy, done, err;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcd_bin_seq dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_bcd3     (bcd3),
    .i_bcd2     (bcd2),
    .i_bcd1     (bcd1),
    .i_bcd0     (bcd0),
    .o_bi       (bi),
    .o_busy     (busy),
    .o_done     (done),
    .o_err      (err),
    .o_dbg_state(dbg_state)
  );

  // Reference: decimal value of the digits, or 0 when any digit is not 0..9.
  function automatic logic [15:0] ref_bin(input int d3, input int d2, input int d1, input int d0);
    if (d3 > 9 || d2 > 9 || d1 > 9 || d0 > 9) return 16'd0;
    return 16'(d3 * 1000 + d2 * 100 + d1 * 10 + d0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_digits(input int d3, input int d2, input int d1, input int d0);
    bcd3 = 4'(d3);
    bcd2 = 4'(d2);
    bcd1 = 4'(d1);
    bcd0 = 4'(d0);
  endtask

  // Bounded wait for the done pulse; lat counts edges waited.
  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic convert(input int d3, input int d2, input int d1, input int d0, input string tag);
    int lat;
    logic bad;
    logic [15:0] e;
    bad = (d3 > 9 || d2 > 9 || d1 > 9 || d0 > 9);
    set_digits(d3, d2, d1, d0);
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_q.push_back(ref_bin(d3, d2, d1, d0));
    chk({tag, "_busy_after_accept"}, 16'(busy), 16'd1);
    wait_done(lat);
    chk({tag, "_latency"}, 16'(lat), bad ? 16'd0 : 16'd16);
    e = exp_q.pop_front();
    chk({tag, "_done"}, 16'(done), 16'd1);
    chk({tag, "_bi"}, bi, e);
    chk({tag, "_err"}, 16'(err), 16'(bad));
    tick();
    chk({tag, "_done_cleared"}, 16'(done), 16'd0);
    chk({tag, "_busy_cleared"}, 16'(busy), 16'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, ndone, v, prev_done;
    logic [15:0] e;

    rst = 1'b1;
    start = 1'b0;
    set_digits(0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
    chk("reset_bi", bi, 16'h0000);
    chk("reset_busy", 16'(busy), 16'd0);
    chk("reset_done", 16'(done), 16'd0);
    chk("reset_err", 16'(err), 16'd0);

    convert(9, 9, 9, 9, "max");
    chk("max_const", bi, 16'h270F);
    convert(1, 2, 3, 4, "c1234");
    chk("c1234_const", bi, 16'h04D2);
    convert(0, 0, 0, 0, "zero");
    chk("zero_const", bi, 16'h0000);
    convert(0, 0, 0, 1, "one");
    chk("one_const", bi, 16'h0001);

    convert(0, 10, 0, 0, "bad_hundreds");
    chk("bad_hundreds_err_held", 16'(err), 16'd1);
    chk("bad_hundreds_bi_zero", bi, 16'h0000);
    convert(0, 0, 4, 2, "after_bad");
    chk("after_bad_const", bi, 16'h002A);

    // Start pulse and digit change mid-conversion must be ignored.
    set_digits(5, 6, 7, 8);
    start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    start = 1'b1;
    set_digits(1, 1, 1, 1);
    tick();
    start = 1'b0;
    wait_done(lat);
    chk("ignore_latency_from_e5", 16'(lat), 16'd11);
    chk("ignore_bi", bi, 16'h162E);
    chk("ignore_err", 16'(err), 16'd0);
    ndone++;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    chk("ignore_single_done", 16'(ndone), 16'd1);

    // Reset mid-conversion.
    set_digits(9, 9, 9, 9);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_bi", bi, 16'h0000);
    chk("midrst_busy", 16'(busy), 16'd0);
    chk("midrst_done", 16'(done), 16'd0);
    chk("midrst_err", 16'(err), 16'd0);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done === 1'b1) ndone++;
    end
    chk("midrst_no_done", 16'(ndone), 16'd0);
    convert(0, 1, 0, 0, "after_rst");
    chk("after_rst_const", bi, 16'h0064);

    // Random digits, invalid codes included.
    for (int i = 0; i < 20; i++) begin
      convert($urandom_range(0, 15), $urandom_range(0, 15),
              $urandom_range(0, 15), $urandom_range(0, 15), "rand_mix");
    end

    // Back-to-back valid conversions with start held high.
    v = $urandom_range(0, 9999);
    set_digits(v / 1000, (v / 100) % 10, (v / 10) % 10, v % 10);
    exp_q.push_back(16'(v));
    start = 1'b1;
    tick();
    prev_done = -1;
    for (int i = 0; i < 200; i++) begin
      set_digits($urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 15), $urandom_range(0, 15));
      wait_done(lat);
      chk("sweep_done_seen", 16'(done), 16'd1);
      chk("sweep_latency", 16'(lat), 16'd16);
      if (prev_done >= 0) chk("sweep_spacing", 16'(cyc - prev_done), 16'd18);
      prev_done = cyc;
      e = exp_q.pop_front();
      chk("sweep_bi", bi, e);
      chk("sweep_err", 16'(err), 16'd0);
      if (i < 199) begin
        v = (i == 0) ? 9999 : (i == 1) ? 0 : $urandom_range(0, 9999);
        set_digits(v / 1000, (v / 100) % 10, (v / 10) % 10, v % 10);
        exp_q.push_back(16'(v));
        tick();
        tick();
      end
    end
    start = 1'b0;
    tick();
    tick();
    chk("final_idle_busy", 16'(busy), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
